// File: rtl/repair_alloc_scheduler.sv
// Row-remapping allocation sequencer: captures a fault map on start, initialises
// the mapping table, then issues exactly one allocation command per logical
// weight row and reports matched/degraded statistics.
module repair_alloc_scheduler #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int CNT_WIDTH     = ADDR_WIDTH + 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] faulty_pe_map,
    output logic                                   wt_rd_en,
    output logic [ADDR_WIDTH-1:0]                  wt_rd_addr,
    input  logic [SYSTOLIC_SIZE-1:0]               wt_zero_mask,
    output logic                                   tbl_wr_en,
    output logic [SYSTOLIC_SIZE-1:0]               tbl_faulty_rows_mask,
    output logic                                   tbl_match_success,
    output logic                                   tbl_match_failed,
    output logic                                   tbl_all_faulty_matched,
    output logic [ADDR_WIDTH-1:0]                  tbl_faulty_addr,
    output logic [ADDR_WIDTH-1:0]                  tbl_current_row_addr,
    input  logic                                   tbl_allocation_failed,
    output logic                                   busy,
    output logic                                   done,
    output logic [CNT_WIDTH-1:0]                   success_cnt,
    output logic [CNT_WIDTH-1:0]                   degraded_cnt,
    output logic [SYSTOLIC_SIZE-1:0]               unmatched_mask
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_INIT_WAIT, S_FETCH, S_MATCH, S_ISSUE, S_CHECK, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    state_t                                 state;
    logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] fault_map;
    logic [SYSTOLIC_SIZE-1:0]               matched;
    logic [ADDR_WIDTH-1:0]                  row_cnt;
    logic                                   wait_cnt;

    logic [SYSTOLIC_SIZE-1:0]               start_rows;
    logic                                   cand_found;
    logic [ADDR_WIDTH-1:0]                  cand_addr;
    logic                                   unmatched_any;

    // Per-row OR of the incoming fault map, captured on an accepted start.
    always_comb begin
        start_rows = '0;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            start_rows[r] = |faulty_pe_map[r*SYSTOLIC_SIZE +: SYSTOLIC_SIZE];
        end
    end

    // Lowest unmatched faulty row whose faulty PEs all sit under zero weights.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        cand_found = 1'b0;
        cand_addr  = '0;
        for (int f = SYSTOLIC_SIZE - 1; f >= 0; f--) begin
            if (tbl_faulty_rows_mask[f] && !matched[f] &&
                ((fault_map[f*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] & ~wt_zero_mask) == '0)) begin
                cand_found = 1'b1;
                cand_addr  = ADDR_WIDTH'(f);
            end
        end
        unmatched_any = |(tbl_faulty_rows_mask & ~matched);
    end

    // Sequencer FSM; every output is registered and set on entry to its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the captured map is plain flops, so clearing it costs nothing and
            // keeps every derived output at 0 after reset.
            state                  <= S_IDLE;
            fault_map              <= '0;
            matched                <= '0;
            row_cnt                <= '0;
            wait_cnt               <= 1'b0;
            wt_rd_en               <= 1'b0;
            wt_rd_addr             <= '0;
            tbl_wr_en              <= 1'b0;
            tbl_faulty_rows_mask   <= '0;
            tbl_match_success      <= 1'b0;
            tbl_match_failed       <= 1'b0;
            tbl_all_faulty_matched <= 1'b0;
            tbl_faulty_addr        <= '0;
            tbl_current_row_addr   <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            success_cnt            <= '0;
            degraded_cnt           <= '0;
            unmatched_mask         <= '0;
        end else begin
            // NOTE: non-blocking throughout; pulses default low and are re-armed
            // only by the state that owns them.
            wt_rd_en               <= 1'b0;
            tbl_wr_en              <= 1'b0;
            tbl_match_success      <= 1'b0;
            tbl_match_failed       <= 1'b0;
            tbl_all_faulty_matched <= 1'b0;
            tbl_faulty_addr        <= '0;
            tbl_current_row_addr   <= '0;
            done                   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        fault_map            <= faulty_pe_map;
                        tbl_faulty_rows_mask <= start_rows;
                        matched              <= '0;
                        row_cnt              <= '0;
                        success_cnt          <= '0;
                        degraded_cnt         <= '0;
                        unmatched_mask       <= '0;
                        tbl_wr_en            <= 1'b1;
                        busy                 <= 1'b1;
                        state                <= S_INIT;
                    end
                end
                S_INIT: begin
                    wait_cnt <= 1'b0;
                    state    <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (wait_cnt) begin
                        wt_rd_en   <= 1'b1;
                        wt_rd_addr <= row_cnt;
                        state      <= S_FETCH;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_MATCH;
                end
                S_MATCH: begin
                    tbl_current_row_addr <= row_cnt;
                    if (cand_found) begin
                        tbl_match_success <= 1'b1;
                        tbl_faulty_addr   <= cand_addr;
                    end else if (!unmatched_any) begin
                        tbl_all_faulty_matched <= 1'b1;
                    end else begin
                        tbl_match_failed <= 1'b1;
                    end
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (tbl_match_success) begin
                        matched[tbl_faulty_addr] <= 1'b1;
                        success_cnt              <= success_cnt + CNT_WIDTH'(1);
                    end
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (tbl_allocation_failed) begin
                        degraded_cnt <= degraded_cnt + CNT_WIDTH'(1);
                    end
                    if (row_cnt == LAST_ROW) begin
                        done           <= 1'b1;
                        unmatched_mask <= tbl_faulty_rows_mask & ~matched;
                        state          <= S_DONE;
                    end else begin
                        row_cnt    <= row_cnt + ADDR_WIDTH'(1);
                        wt_rd_en   <= 1'b1;
                        wt_rd_addr <= row_cnt + ADDR_WIDTH'(1);
                        state      <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_repair_alloc_scheduler.sv
// Scoreboard bench for repair_alloc_scheduler: a reference model expands each
// pass into a timed list of expected events; a monitor pops and compares them.
module tb_repair_alloc_scheduler;

    localparam int S  = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    typedef enum int {EV_INIT, EV_RD, EV_SUCC, EV_FAIL, EV_ALLM, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       a;
        int       b;
        int       c;
        int       d;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [S*S-1:0] faulty_pe_map = '0;
    logic           wt_rd_en;
    logic [AW-1:0]  wt_rd_addr;
    logic [S-1:0]   wt_zero_mask = '0;
    logic           tbl_wr_en;
    logic [S-1:0]   tbl_faulty_rows_mask;
    logic           tbl_match_success;
    logic           tbl_match_failed;
    logic           tbl_all_faulty_matched;
    logic [AW-1:0]  tbl_faulty_addr;
    logic [AW-1:0]  tbl_current_row_addr;
    logic           tbl_allocation_failed = 1'b0;
    logic           busy;
    logic           done;
    logic [CW-1:0]  success_cnt;
    logic [CW-1:0]  degraded_cnt;
    logic [S-1:0]   unmatched_mask;

    repair_alloc_scheduler #(.SYSTOLIC_SIZE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .faulty_pe_map(faulty_pe_map),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_zero_mask(wt_zero_mask),
        .tbl_wr_en(tbl_wr_en), .tbl_faulty_rows_mask(tbl_faulty_rows_mask),
        .tbl_match_success(tbl_match_success), .tbl_match_failed(tbl_match_failed),
        .tbl_all_faulty_matched(tbl_all_faulty_matched), .tbl_faulty_addr(tbl_faulty_addr),
        .tbl_current_row_addr(tbl_current_row_addr),
        .tbl_allocation_failed(tbl_allocation_failed), .busy(busy), .done(done),
        .success_cnt(success_cnt), .degraded_cnt(degraded_cnt), .unmatched_mask(unmatched_mask)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    ev_t  exp_q[$];
    logic [S-1:0] masks [S];
    bit           fails [S];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference model: walks the rows with plain arrays and appends timed events.
    task automatic build_expected(input logic [S*S-1:0] m, input int c0);
        bit [S-1:0] rows;
        bit [S-1:0] mt;
        int succ;
        int deg;
        ev_t e;
        rows = '0; mt = '0; succ = 0; deg = 0;
        for (int r = 0; r < S; r++) rows[r] = |m[r*S +: S];
        e = '{EV_INIT, c0 + 1, 0, 0, 0, 0};
        exp_q.push_back(e);
        for (int k = 0; k < S; k++) begin
            int f;
            f = -1;
            e = '{EV_RD, c0 + 4 + 4*k, k, 0, 0, 0};
            exp_q.push_back(e);
            for (int j = S - 1; j >= 0; j--) begin
                logic [S-1:0] rowbits;
                rowbits = m[j*S +: S];
                if (rows[j] && !mt[j] && ((rowbits & ~masks[k]) == '0)) f = j;
            end
            if (f >= 0) begin
                e = '{EV_SUCC, c0 + 6 + 4*k, f, k, 0, 0};
                mt[f] = 1'b1;
                succ++;
            end else if ((rows & ~mt) == '0) begin
                e = '{EV_ALLM, c0 + 6 + 4*k, 0, k, 0, 0};
            end else begin
                e = '{EV_FAIL, c0 + 6 + 4*k, 0, k, 0, 0};
            end
            exp_q.push_back(e);
            if (fails[k]) deg++;
        end
        e = '{EV_DONE, c0 + 4*S + 4, succ, deg, int'(rows & ~mt), int'(rows)};
        exp_q.push_back(e);
    endtask

    function automatic string kname(input ev_kind_t k);
        case (k)
            EV_INIT: return "init";
            EV_RD:   return "rd";
            EV_SUCC: return "success";
            EV_FAIL: return "failed";
            EV_ALLM: return "all_matched";
            default: return "done";
        endcase
    endfunction

    task automatic pop_cmp(input ev_kind_t k, input int a, input int b, input int c, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 1'b0,
                  $sformatf("got %s at cycle %0d, required none", kname(k), cyc));
        end else begin
            e = exp_q.pop_front();
            check($sformatf("event_%s", kname(e.kind)),
                  e.kind == k && e.cyc == cyc && e.a == a && e.b == b && e.c == c && e.d == d,
                  $sformatf("got %s cyc=%0d a=%0d b=%0d c=%0h d=%0h, required %s cyc=%0d a=%0d b=%0d c=%0h d=%0h",
                            kname(k), cyc, a, b, c, d, kname(e.kind), e.cyc, e.a, e.b, e.c, e.d));
        end
    endtask

    // Monitor and responder: answers reads/allocations and scores every output event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tbl_wr_en) pop_cmp(EV_INIT, 0, 0, 0, 0);
            if (wt_rd_en) begin
                wt_zero_mask = masks[wt_rd_addr];
                pop_cmp(EV_RD, int'(wt_rd_addr), 0, 0, 0);
            end
            if (tbl_match_success || tbl_match_failed || tbl_all_faulty_matched)
                tbl_allocation_failed = fails[tbl_current_row_addr];
            if (tbl_match_success)
                pop_cmp(EV_SUCC, int'(tbl_faulty_addr), int'(tbl_current_row_addr), 0, 0);
            if (tbl_match_failed)
                pop_cmp(EV_FAIL, int'(tbl_faulty_addr), int'(tbl_current_row_addr), 0, 0);
            if (tbl_all_faulty_matched)
                pop_cmp(EV_ALLM, int'(tbl_faulty_addr), int'(tbl_current_row_addr), 0, 0);
            if (done) begin
                done_cnt++;
                pop_cmp(EV_DONE, int'(success_cnt), int'(degraded_cnt),
                        int'(unmatched_mask), int'(tbl_faulty_rows_mask));
            end
        end
    end

    task automatic set_masks(input logic [S-1:0] m0, input logic [S-1:0] m1,
                             input logic [S-1:0] rest, input bit f);
        for (int r = 0; r < S; r++) begin
            masks[r] = (r == 0) ? m0 : (r == 1) ? m1 : rest;
            fails[r] = f;
        end
    endtask

    task automatic start_pass(input logic [S*S-1:0] m);
        @(posedge clk); #1;
        faulty_pe_map = m;
        start = 1'b1;
        build_expected(m, cyc);
    endtask

    // One full pass; with noisy set, start is re-pulsed (with a scrambled map)
    // while busy and again during DONE.
    task automatic run_pass(input logic [S*S-1:0] m, input bit noisy);
        int d0;
        d0 = done_cnt;
        start_pass(m);
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            start = noisy && (t == 10 || t == 23 || t == 36);
            if (start) faulty_pe_map = {$urandom, $urandom};
        end
        start = 1'b0;
        check("done_seen", done_cnt == d0 + 1,
              $sformatf("done pulses=%0d, required 1", done_cnt - d0));
        check("queue_drained", exp_q.size() == 0,
              $sformatf("pending events=%0d, required 0", exp_q.size()));
        check("idle_after_pass", busy == 1'b0, $sformatf("busy=%0b, required 0", busy));
    endtask

    task automatic check_all_zero(input string name);
        logic [63:0] v;
        v = {busy, done, wt_rd_en, tbl_wr_en, tbl_match_success, tbl_match_failed,
             tbl_all_faulty_matched, tbl_faulty_addr, tbl_current_row_addr, wt_rd_addr,
             success_cnt, degraded_cnt, unmatched_mask, tbl_faulty_rows_mask};
        check(name, v == '0, $sformatf("outputs=%0h, required 0", v));
    endtask

    initial begin
        logic [S*S-1:0] m;
        set_masks('0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // No faults: every row takes the all-faulty-matched branch.
        run_pass('0, 1'b0);
        // Single fault PE(3,5): row0 fails, row1 matches fault row 3.
        set_masks(8'h00, 8'h20, 8'h00, 1'b0);
        run_pass(64'd1 << 29, 1'b0);
        // Faults PE(2,0), PE(6,0): rows 0 and 1 each match one.
        set_masks(8'h01, 8'h01, 8'h00, 1'b0);
        run_pass((64'd1 << 16) | (64'd1 << 48), 1'b0);
        // Fault PE(4,7), table reports failure every row.
        set_masks(8'h00, 8'h00, 8'h00, 1'b1);
        run_pass(64'd1 << 39, 1'b0);
        // All-zero weights with faulty rows 1 and 5.
        set_masks(8'hFF, 8'hFF, 8'hFF, 1'b0);
        run_pass((64'd1 << 10) | (64'd1 << 46), 1'b0);
        // Start re-pulsed while busy and in DONE: ignored.
        set_masks(8'h00, 8'h20, 8'h00, 1'b0);
        run_pass(64'd1 << 29, 1'b1);

        // Randomised passes.
        for (int p = 0; p < 8; p++) begin
            m = '0;
            for (int i = 0; i < S*S; i++) m[i] = ($urandom_range(0, 11) == 0);
            for (int r = 0; r < S; r++) begin
                masks[r] = ($urandom_range(0, 2) == 0) ? 8'hFF : S'($urandom | $urandom);
                fails[r] = bit'($urandom_range(0, 1));
            end
            run_pass(m, p[0]);
        end

        // Reset during row 4 abandons the pass.
        set_masks('0, '0, '0, 1'b0);
        start_pass('0);
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("mid_pass_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_pulses_after_reset", exp_q.size() == 0 && busy == 1'b0,
              $sformatf("busy=%0b, required 0", busy));
        // Fresh start reproduces the first-run sequence.
        run_pass('0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
